// File: rtl/adder_arbiter_if.sv
// Bundle between two requesters, the arbiter and a shared multi-cycle adder.
// The master modport is the arbiter's view; slave is the requesters+adder side.
interface adder_arbiter_if #(
    parameter int WIDTH = 1025
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sub0;
    logic             sub1;
    logic             shift0;
    logic             shift1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [WIDTH:0]   result;
    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_subtract;
    logic             add_shift;
    logic [WIDTH:0]   add_result;
    logic             add_done;

    modport master (
        input  req0, req1, a0, b0, a1, b1, sub0, sub1, shift0, shift1,
        input  add_result, add_done,
        output ack0, ack1, done0, done1, result,
        output add_start, add_a, add_b, add_subtract, add_shift
    );

    modport slave (
        output req0, req1, a0, b0, a1, b1, sub0, sub1, shift0, shift1,
        output add_result, add_done,
        input  ack0, ack1, done0, done1, result,
        input  add_start, add_a, add_b, add_subtract, add_shift
    );
endinterface

// File: rtl/adder_arbiter.sv
// Two-port arbiter sharing one multi-cycle adder, one operation in flight.
// Define ADDER_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0).
module adder_arbiter #(
    parameter int WIDTH = 1025
) (
    input  logic              clk,
    input  logic              resetn,
    adder_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_reg, state_next;
    logic             grant_reg, grant_next;
    logic [WIDTH-1:0] add_a_reg, add_a_next;
    logic [WIDTH-1:0] add_b_reg, add_b_next;
    logic             add_sub_reg, add_sub_next;
    logic             add_shift_reg, add_shift_next;
    logic [WIDTH:0]   result_reg, result_next;

    logic [1:0]       req_vec;
    logic [WIDTH-1:0] a_arr [2];
    logic [WIDTH-1:0] b_arr [2];
    logic [1:0]       sub_vec;
    logic [1:0]       shift_vec;
    logic [1:0]       ack_vec;
    logic [1:0]       done_vec;
    logic             win;
    logic             ack_en;
    logic             start_en;
    logic             done_en;

    assign req_vec   = {bus.req1, bus.req0};
    assign a_arr[0]  = bus.a0;
    assign a_arr[1]  = bus.a1;
    assign b_arr[0]  = bus.b0;
    assign b_arr[1]  = bus.b1;
    assign sub_vec   = {bus.sub1, bus.sub0};
    assign shift_vec = {bus.shift1, bus.shift0};

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    // prio_reg names the port that wins the next contention: always the one
    // not granted last, so after reset port 0 is favoured.
    logic prio_reg, prio_next;

    assign win = (req_vec == 2'b11) ? prio_reg : req_vec[1];
`else
    assign win = ~req_vec[0];
`endif

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        add_a_next     = add_a_reg;
        add_b_next     = add_b_reg;
        add_sub_next   = add_sub_reg;
        add_shift_next = add_shift_reg;
        result_next    = result_reg;
        ack_en         = 1'b0;
        start_en       = 1'b0;
        done_en        = 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
        prio_next      = prio_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    grant_next     = win;
                    add_a_next     = a_arr[win];
                    add_b_next     = b_arr[win];
                    add_sub_next   = sub_vec[win];
                    add_shift_next = shift_vec[win];
                    ack_en         = 1'b1;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
                    prio_next      = ~win;
`endif
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                start_en   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // add_done is only meaningful here; elsewhere it is a stray pulse
                if (bus.add_done) begin
                    result_next = bus.add_result;
                    state_next  = RESP;
                end
            end
            RESP: begin
                done_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            grant_reg     <= 1'b0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            add_sub_reg   <= 1'b0;
            add_shift_reg <= 1'b0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            add_a_reg     <= add_a_next;
            add_b_reg     <= add_b_next;
            add_sub_reg   <= add_sub_next;
            add_shift_reg <= add_shift_next;
            result_reg    <= result_next;
        end
    end

`ifdef ADDER_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end
`endif

    // ack is decoded in IDLE so the grant and operand capture share one edge;
    // all pulses are held low while reset is asserted.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign ack_vec[gi]  = resetn && ack_en  && (win == 1'(gi));
            assign done_vec[gi] = resetn && done_en && (grant_reg == 1'(gi));
        end
    endgenerate

    assign bus.ack0         = ack_vec[0];
    assign bus.ack1         = ack_vec[1];
    assign bus.done0        = done_vec[0];
    assign bus.done1        = done_vec[1];
    assign bus.add_start    = resetn && start_en;
    assign bus.add_a        = add_a_reg;
    assign bus.add_b        = add_b_reg;
    assign bus.add_subtract = add_sub_reg;
    assign bus.add_shift    = add_shift_reg;
    assign bus.result       = result_reg;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed table, reset/stray-done/contention sequences
// and randomized traffic checked against an arbitration and adder model.
module tb_adder_arbiter;
    localparam int W = 1025;
    typedef logic [W-1:0] opnd_t;
    typedef logic [W:0]   res_t;

    typedef struct {
        int    port;
        opnd_t a;
        opnd_t b;
        bit    sub;
        bit    shift;
        int    lat;
        res_t  exp_result;
    } vec_t;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    opnd_t op_a [2];
    opnd_t op_b [2];
    bit    op_sub [2];
    bit    op_shift [2];
    bit    req_v [2];
    bit    rr_pref;
    res_t  last_result;
    vec_t  vecs [5];

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input res_t act, input res_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (low 128 bits)", nm, act[127:0], exp[127:0]);
        end
    endtask

    always @(negedge clk) begin
        check("ack_exclusive", res_t'(bus.ack0 & bus.ack1), '0);
        check("done_exclusive", res_t'(bus.done0 & bus.done1), '0);
    end

    // Behavioural adder: plain arithmetic on the operand values.
    function automatic res_t adder_model(opnd_t a, opnd_t b, bit sub, bit shift);
        res_t r;
        r = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        if (shift) r = r << 1;
        return r;
    endfunction

    function automatic int pick_winner(bit r0, bit r1);
        if (r0 && r1) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            return int'(rr_pref);
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    function automatic opnd_t rand_wide();
        opnd_t v;
        if ($urandom_range(0, 3) == 0) return opnd_t'($urandom);
        for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic drive();
        bus.req0   = req_v[0];  bus.req1   = req_v[1];
        bus.a0     = op_a[0];   bus.a1     = op_a[1];
        bus.b0     = op_b[0];   bus.b1     = op_b[1];
        bus.sub0   = op_sub[0]; bus.sub1   = op_sub[1];
        bus.shift0 = op_shift[0]; bus.shift1 = op_shift[1];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE with requests already driven; runs one whole operation.
    task automatic serve_op(input int exp_port, input int lat, input res_t drv_res, input res_t exp_res);
        int    waited;
        bit    got;
        int    who;
        opnd_t ea, eb;
        bit    es, eh;
        waited = 0;
        got    = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) got = 1;
            else begin
                waited++;
                next_cycle();
            end
        end
        check("ack_seen", res_t'(got), res_t'(1));
        if (!got) return;
        who = bus.ack1 ? 1 : 0;
        check("ack_port", res_t'(who), res_t'(exp_port));
        check("ack_latency", res_t'(waited), '0);
        ea = op_a[exp_port]; eb = op_b[exp_port];
        es = op_sub[exp_port]; eh = op_shift[exp_port];
        next_cycle();
        // winner withdraws and scrambles its operands; the capture must hold
        req_v[who]   = 0;
        op_a[who]    = rand_wide();
        op_b[who]    = rand_wide();
        op_sub[who]  = 1'($urandom_range(0, 1));
        op_shift[who] = 1'($urandom_range(0, 1));
        drive();
        @(negedge clk);
        check("add_start_pulse", res_t'(bus.add_start), res_t'(1));
        check("add_a", res_t'(bus.add_a), res_t'(ea));
        check("add_b", res_t'(bus.add_b), res_t'(eb));
        check("add_subtract", res_t'(bus.add_subtract), res_t'(es));
        check("add_shift", res_t'(bus.add_shift), res_t'(eh));
        check("ack_in_issue", res_t'({bus.ack1, bus.ack0}), '0);
        for (int i = 0; i < lat; i++) begin
            next_cycle();
            @(negedge clk);
            check("wait_quiet", res_t'({bus.add_start, bus.done1, bus.done0}), '0);
        end
        next_cycle();
        bus.add_done   = 1'b1;
        bus.add_result = drv_res;
        @(negedge clk);
        check("done_early", res_t'({bus.done1, bus.done0}), '0);
        next_cycle();
        bus.add_done   = 1'b0;
        bus.add_result = res_t'(rand_wide());
        @(negedge clk);
        check("done_port", res_t'({bus.done1, bus.done0}), (exp_port == 1) ? res_t'(2) : res_t'(1));
        check("result", bus.result, exp_res);
        last_result = exp_res;
        rr_pref = (exp_port == 0);
        next_cycle();
    endtask

    initial begin
        int   exp_port;
        res_t r;
        opnd_t ones;
        total = 0;
        bad   = 0;
        rr_pref = 0;
        last_result = '0;
        ones = '1;

        vecs[0] = '{port: 0, a: opnd_t'(5),  b: opnd_t'(3), sub: 0, shift: 0, lat: 3, exp_result: res_t'(8)};
        vecs[1] = '{port: 1, a: opnd_t'(10), b: opnd_t'(3), sub: 1, shift: 1, lat: 2, exp_result: res_t'(14)};
        vecs[2] = '{port: 0, a: ones, b: ones, sub: 0, shift: 0, lat: 0, exp_result: {1'b1, {(W-1){1'b1}}, 1'b0}};
        vecs[3] = '{port: 1, a: '0, b: opnd_t'(1), sub: 1, shift: 0, lat: 1, exp_result: '1};
        vecs[4] = '{port: 0, a: '0, b: '0, sub: 0, shift: 1, lat: 5, exp_result: '0};

        for (int p = 0; p < 2; p++) begin
            req_v[p] = 0; op_a[p] = '0; op_b[p] = '0; op_sub[p] = 0; op_shift[p] = 0;
        end
        resetn = 1'b0;
        req_v[0] = 1; op_a[0] = opnd_t'(5); op_b[0] = opnd_t'(3);
        drive();
        bus.add_done = 1'b0;
        bus.add_result = '0;

        // Reset held with req0 up: nothing may move.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            check("rst_pulses", res_t'({bus.ack0, bus.ack1, bus.add_start, bus.done0, bus.done1}), '0);
            check("rst_result", bus.result, '0);
            check("rst_add_a", res_t'(bus.add_a), '0);
            check("rst_modes", res_t'({bus.add_subtract, bus.add_shift}), '0);
        end
        next_cycle();
        resetn = 1'b1;
        req_v[0] = 0;
        drive();
        bus.add_done = 1'b1;
        bus.add_result = res_t'(77);
        @(negedge clk);
        check("post_rst_done", res_t'({bus.done1, bus.done0, bus.ack1, bus.ack0}), '0);
        next_cycle();
        bus.add_done = 1'b0;
        @(negedge clk);
        check("post_rst_quiet", res_t'({bus.add_start, bus.done1, bus.done0}), '0);
        check("post_rst_result", bus.result, '0);
        next_cycle();

        // Directed single operations.
        for (int i = 0; i < 5; i++) begin
            req_v[vecs[i].port]    = 1;
            op_a[vecs[i].port]     = vecs[i].a;
            op_b[vecs[i].port]     = vecs[i].b;
            op_sub[vecs[i].port]   = vecs[i].sub;
            op_shift[vecs[i].port] = vecs[i].shift;
            drive();
            r = adder_model(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].shift);
            serve_op(vecs[i].port, vecs[i].lat, r, vecs[i].exp_result);
        end

        // Stray add_done in IDLE.
        bus.add_done = 1'b1;
        bus.add_result = res_t'(12345);
        @(negedge clk);
        check("stray_done", res_t'({bus.done1, bus.done0}), '0);
        next_cycle();
        bus.add_done = 1'b0;
        @(negedge clk);
        check("stray_result", bus.result, last_result);
        check("stray_done2", res_t'({bus.done1, bus.done0}), '0);
        next_cycle();

        // Reset while waiting for the adder.
        req_v[0] = 1; op_a[0] = opnd_t'(9); op_b[0] = opnd_t'(4);
        drive();
        @(negedge clk);
        check("midrst_ack", res_t'(bus.ack0), res_t'(1));
        next_cycle();
        req_v[0] = 0;
        drive();
        next_cycle();
        next_cycle();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        bus.add_done = 1'b1;
        bus.add_result = res_t'(13);
        @(negedge clk);
        check("midrst_done", res_t'({bus.done1, bus.done0}), '0);
        check("midrst_result", bus.result, '0);
        next_cycle();
        bus.add_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_quiet", res_t'({bus.add_start, bus.done1, bus.done0, bus.ack1, bus.ack0}), '0);
            check("midrst_result_hold", bus.result, '0);
            next_cycle();
        end
        rr_pref = 0;
        last_result = '0;

        // Contention: both ports hold requests across four operations.
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1; op_a[p] = rand_wide(); op_b[p] = rand_wide();
            op_sub[p] = 0; op_shift[p] = 0;
        end
        drive();
        for (int i = 0; i < 4; i++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
            exp_port = i % 2;
`else
            exp_port = 0;
`endif
            r = adder_model(op_a[exp_port], op_b[exp_port], op_sub[exp_port], op_shift[exp_port]);
            serve_op(exp_port, 1, r, r);
            req_v[exp_port] = 1;
            op_a[exp_port] = rand_wide();
            op_b[exp_port] = rand_wide();
            drive();
        end
        req_v[0] = 0; req_v[1] = 0;
        drive();
        next_cycle();

        // Randomized traffic; a losing request stays pending until served.
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_v[p] && $urandom_range(0, 1) == 1) begin
                    req_v[p] = 1;
                    op_a[p] = rand_wide();
                    op_b[p] = rand_wide();
                    op_sub[p] = 1'($urandom_range(0, 1));
                    op_shift[p] = 1'($urandom_range(0, 1));
                end
            end
            if (!req_v[0] && !req_v[1]) begin
                req_v[it % 2] = 1;
                op_a[it % 2] = rand_wide();
                op_b[it % 2] = rand_wide();
            end
            drive();
            exp_port = pick_winner(req_v[0], req_v[1]);
            r = adder_model(op_a[exp_port], op_b[exp_port], op_sub[exp_port], op_shift[exp_port]);
            serve_op(exp_port, int'($urandom_range(0, 3)), r, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
